// File: rtl/freq2noteid.sv
// freq2noteid: converts an integer frequency in Hz to the nearest note id
// (note n = C0 * ratio^n, note 0 = rest). Iterative search, one semitone per
// clock, using the same fixed-point constants and per-step truncation as the
// note-to-frequency path so a round trip agrees.
// Optional feature macro: LAST_CACHE_EN (remembers the last completed
// conversion and answers a repeated frequency without searching).
//
// Handshake: req is looked at only in IDLE and only when done is low; a
// request seen while busy, in DONE, or in the done cycle is dropped, never
// queued. freq is captured on acceptance. done is a one-cycle registered
// pulse that coincides with the update of noteid, which then holds.
module freq2noteid (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] freq,
  output logic        busy,
  output logic        done,
  output logic [7:0]  noteid
);

  localparam logic [23:0] C0X1024    = 24'd8372;
  localparam logic [35:0] RATIOX1024 = 36'd1085;
  localparam logic [35:0] HALFX1024  = 36'd1054;
  localparam logic [7:0]  MAX_NOTE   = 8'd127;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [25:0] target_q, target_d;
  logic [23:0] fcur_q, fcur_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  noteid_q, noteid_d;

  logic [35:0] mid_prod;
  logic [35:0] step_prod;
  logic [25:0] mid;
  logic [23:0] fcur_step;
  logic        stop;
  logic        accept;
  logic        hit;

  // Rounding threshold and next candidate frequency, both truncated after >>10
  assign mid_prod  = {12'd0, fcur_q} * HALFX1024;
  assign step_prod = {12'd0, fcur_q} * RATIOX1024;
  assign mid       = mid_prod[35:10];
  assign fcur_step = step_prod[33:10];
  // A tie (target == mid) keeps searching, i.e. rounds up
  assign stop      = (target_q < mid) || (n_q == MAX_NOTE);
  assign accept    = (state_q == IDLE) && req && !done_q;

`ifdef LAST_CACHE_EN
  logic [15:0] last_freq_q, last_freq_d;
  logic [7:0]  last_note_q, last_note_d;
  logic        cache_vld_q, cache_vld_d;

  assign hit = cache_vld_q && (freq == last_freq_q);

  // Cache of the most recently completed conversion
  always_comb begin
    last_freq_d = last_freq_q;
    last_note_d = last_note_q;
    cache_vld_d = cache_vld_q;
    if (state_q == DONE) begin
      last_freq_d = target_q[25:10];
      last_note_d = result_q;
      cache_vld_d = 1'b1;
    end
  end

  // Cache registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_freq_q <= '0;
      last_note_q <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      last_freq_q <= last_freq_d;
      last_note_q <= last_note_d;
      cache_vld_q <= cache_vld_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ((freq == 16'd0) || hit) ? DONE : CALC;
      CALC: if (stop) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    target_d = target_q;
    fcur_d   = fcur_q;
    n_d      = n_q;
    result_d = result_q;
    busy_d   = (state_d == CALC);
    done_d   = (state_q == DONE);
    noteid_d = (state_q == DONE) ? result_q : noteid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = {freq, 10'd0};
          fcur_d   = C0X1024;
          n_d      = 8'd0;
          if (freq == 16'd0) result_d = 8'd0;
`ifdef LAST_CACHE_EN
          else if (hit) result_d = last_note_q;
`endif
        end
      end
      CALC: begin
        if (stop) begin
          // Note 0 is reserved for rest, so a nonzero input reports at least 1
          result_d = (n_q == 8'd0) ? 8'd1 : n_q;
        end else begin
          fcur_d = fcur_step;
          n_d    = n_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target_q <= '0;
      fcur_q   <= '0;
      n_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      noteid_q <= '0;
    end else begin
      target_q <= target_d;
      fcur_q   <= fcur_d;
      n_q      <= n_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      noteid_q <= noteid_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign noteid = noteid_q;

endmodule
